sample_serializer: RTL and testbench

Parametrised byte serializer between the demodulator's sample path and the UART transmitter. It buffers WIDTH-bit signed samples in a small FIFO and emits each one as a framed byte stream: an optional header byte, then ceil(WIDTH/8) data bytes in the selected byte order. Byte transfer uses a valid/ready handshake with the UART TX, so no samples are lost while the UART is busy. It generalises the fixed 16-bit, two-byte split to any width, FIFO depth and byte order, and adds overflow reporting.

---
 rtl/fmdemod_pkg.sv | 17 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/sample_serializer.sv | 142 ++++++++++++++
 tb/tb_sample_serializer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmdemod_pkg.sv
// Shared definitions for the demodulator sample path: serializer states, frame sync
// byte and the bytes-per-sample helper.
package fmdemod_pkg;

   localparam logic [7:0] DefaultHeaderByte = 8'hA5;

   typedef enum logic [1:0] {
      StIdle,
      StHeader,
      StData
   } ser_state_e;

   function automatic int unsigned calc_nbytes(input int unsigned width);
      return (width + 32'd7) / 32'd8;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data and an occupancy count.
module sync_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             wr_ok;
   logic             rd_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem[rd_ptr_q];

   // A write into a full FIFO is only safe when a pop frees the slot on the same edge.
   assign wr_ok = wr_en && (!full || rd_en);
   assign rd_ok = rd_en && !empty;

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/sample_serializer.sv
// Buffers signed samples and emits each as an optional header byte followed by the
// sign-extended sample bytes over a valid/ready byte interface.
module sample_serializer
   import fmdemod_pkg::*;
#(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned DEPTH       = 4,
   parameter bit          MSB_FIRST   = 1'b1,
   parameter bit          HEADER_EN   = 1'b1,
   parameter logic [7:0]  HEADER_BYTE = DefaultHeaderByte
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_valid_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             sample_ready_o,
   output logic             byte_valid_o,
   output logic [7:0]       data_uart_o,
   input  logic             byte_ready_i,
   output logic             frame_done_o,
   output logic             overflow_o,
   input  logic             clr_ovf_i
);

   localparam int unsigned NBYTES = calc_nbytes(WIDTH);
   localparam int unsigned EW     = NBYTES * 8;
   localparam int unsigned IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int unsigned CW     = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] fifo_rd_data;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_count;
   logic             fifo_wr;
   logic             fifo_rd;

   ser_state_e    state_q, state_d;
   logic [EW-1:0] shift_q, shift_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          byte_valid_q, byte_valid_d;
   logic [7:0]    data_uart_q, data_uart_d;
   logic          frame_done_q, frame_done_d;
   logic          overflow_q, overflow_d;

   logic [EW-1:0] ext;
   logic [EW-1:0] shifted;
   logic [IW-1:0] sel;
   logic          load;

   assign sample_ready_o = (fifo_count != CW'(DEPTH));
   assign fifo_wr        = sample_valid_i && sample_ready_o;

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (fifo_wr),
      .wr_data (data_i),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   if (EW > WIDTH) begin : g_sext
      assign ext = {{(EW - WIDTH){fifo_rd_data[WIDTH-1]}}, fifo_rd_data};
   end else begin : g_nosext
      assign ext = fifo_rd_data;
   end

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      idx_d        = idx_q;
      frame_done_d = 1'b0;
      load         = 1'b0;
      unique case (state_q)
         StIdle:   load = !fifo_empty;
         StHeader: if (byte_ready_i) state_d = StData;
         StData: begin
            if (byte_ready_i) begin
               if (idx_q == IW'(NBYTES - 1)) begin
                  frame_done_d = 1'b1;
                  if (!fifo_empty) load = 1'b1;
                  else             state_d = StIdle;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default:  state_d = StIdle;
      endcase
      fifo_rd = load;
      if (load) begin
         shift_d = ext;
         idx_d   = '0;
         state_d = HEADER_EN ? StHeader : StData;
      end
   end

   // Outputs are registered, so the byte for the next state is selected here.
   always_comb begin
      sel          = MSB_FIRST ? (IW'(NBYTES - 1) - idx_d) : idx_d;
      shifted      = shift_d >> {sel, 3'b000};
      byte_valid_d = (state_d != StIdle);
      unique case (state_d)
         StHeader: data_uart_d = HEADER_BYTE;
         StData:   data_uart_d = shifted[7:0];
         default:  data_uart_d = 8'h00;
      endcase
      overflow_d = (overflow_q && !clr_ovf_i) || (sample_valid_i && fifo_full);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         shift_q      <= '0;
         idx_q        <= '0;
         byte_valid_q <= 1'b0;
         data_uart_q  <= 8'h00;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         idx_q        <= idx_d;
         byte_valid_q <= byte_valid_d;
         data_uart_q  <= data_uart_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
      end
   end

   assign byte_valid_o = byte_valid_q;
   assign data_uart_o  = data_uart_q;
   assign frame_done_o = frame_done_q;
   assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_sample_serializer.sv
// Directed and randomized checks of sample_serializer against a frame-level byte model.
module tb_sample_serializer;

   localparam int unsigned W     = 16;
   localparam int unsigned D     = 4;
   localparam int unsigned NB    = 2;
   localparam int unsigned FRAME = NB + 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         sample_valid_i;
   logic [15:0]  data_i;
   logic         sample_ready_o;
   logic         byte_valid_o;
   logic [7:0]   data_uart_o;
   logic         byte_ready_i;
   logic         frame_done_o;
   logic         overflow_o;
   logic         clr_ovf_i;

   logic         v12;
   logic [11:0]  d12;
   logic         sr12;
   logic         bv12;
   logic [7:0]   du12;
   logic         fd12;
   logic         ov12;

   int unsigned  vectors = 0;
   int unsigned  miscompares = 0;
   int unsigned  cyc = 0;

   int unsigned  m_cnt;
   int unsigned  m_left;
   bit           m_fdone;
   bit           m_ovf;
   logic [7:0]   exp_q[$];
   logic [15:0]  pend_q[$];
   logic [7:0]   seen[$];
   int unsigned  seen_cyc[$];

   always #5 clk = ~clk;

   sample_serializer u_dut (
      .clk            (clk),
      .rst            (rst),
      .sample_valid_i (sample_valid_i),
      .data_i         (data_i),
      .sample_ready_o (sample_ready_o),
      .byte_valid_o   (byte_valid_o),
      .data_uart_o    (data_uart_o),
      .byte_ready_i   (byte_ready_i),
      .frame_done_o   (frame_done_o),
      .overflow_o     (overflow_o),
      .clr_ovf_i      (clr_ovf_i)
   );

   sample_serializer #(
      .WIDTH     (12),
      .DEPTH     (4),
      .MSB_FIRST (1'b0),
      .HEADER_EN (1'b0)
   ) u_dut12 (
      .clk            (clk),
      .rst            (rst),
      .sample_valid_i (v12),
      .data_i         (d12),
      .sample_ready_o (sr12),
      .byte_valid_o   (bv12),
      .data_uart_o    (du12),
      .byte_ready_i   (1'b1),
      .frame_done_o   (fd12),
      .overflow_o     (ov12),
      .clr_ovf_i      (1'b0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Byte k (0 = least significant) of the sample sign-extended from width bits.
   function automatic logic [7:0] ext_byte(input int unsigned data, input int unsigned width,
                                           input int unsigned k);
      longint v;
      v = longint'(data);
      if (((data >> (width - 1)) & 1) != 0) v = v - (longint'(1) << width);
      return 8'((v >>> (8 * k)) & 255);
   endfunction

   function automatic void push_frame(input logic [15:0] s);
      exp_q.push_back(8'hA5);
      for (int k = NB - 1; k >= 0; k--) exp_q.push_back(ext_byte(s, W, k));
   endfunction

   // Checks outputs against the model at the falling edge, then advances the model
   // over the coming rising edge.
   task automatic cycle();
      bit acc;
      bit wr;
      bit ovfev;
      @(negedge clk);
      chk("sample_ready", sample_ready_o, m_cnt != D);
      chk("byte_valid", byte_valid_o, m_left > 0);
      if (m_left > 0 && exp_q.size() > 0) chk("data_uart", data_uart_o, exp_q[0]);
      chk("frame_done", frame_done_o, m_fdone);
      chk("overflow", overflow_o, m_ovf);
      if (byte_valid_o && byte_ready_i && !rst) begin
         seen.push_back(data_uart_o);
         seen_cyc.push_back(cyc);
      end
      if (rst) begin
         m_cnt = 0; m_left = 0; m_fdone = 0; m_ovf = 0;
         exp_q.delete(); pend_q.delete();
      end else begin
         acc     = (m_left > 0) && byte_ready_i;
         wr      = sample_valid_i && (m_cnt < D);
         ovfev   = sample_valid_i && (m_cnt == D);
         m_fdone = acc && (m_left == 1);
         if (acc) begin
            void'(exp_q.pop_front());
            m_left--;
         end
         if (m_left == 0 && m_cnt > 0) begin
            push_frame(pend_q.pop_front());
            m_left = FRAME;
            m_cnt--;
         end
         if (wr) begin
            pend_q.push_back(data_i);
            m_cnt++;
         end
         m_ovf = (m_ovf && !clr_ovf_i) || ovfev;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; sample_valid_i = 1'b0; data_i = '0; byte_ready_i = 1'b1; clr_ovf_i = 1'b0;
      v12 = 1'b0; d12 = '0;
      m_cnt = 0; m_left = 0; m_fdone = 0; m_ovf = 0;
      @(posedge clk); #1;
      cycle();
      chk("reset_data_uart", data_uart_o, 8'h00);
      rst = 1'b0;
      cycle();

      // 12-bit, LSB first, no header
      v12 = 1'b1; d12 = 12'h8F3;
      @(posedge clk); #1;
      v12 = 1'b0;
      @(posedge clk); #1;
      chk("w12_valid", bv12, 1'b1);
      chk("w12_byte0", du12, 8'hF3);
      @(posedge clk); #1;
      chk("w12_byte1", du12, 8'hF8);
      @(posedge clk); #1;
      chk("w12_done", fd12, 1'b1);
      chk("w12_idle", bv12, 1'b0);

      // Single sample
      seen.delete(); seen_cyc.delete();
      sample_valid_i = 1'b1; data_i = 16'h1234;
      cycle();
      sample_valid_i = 1'b0;
      repeat (5) cycle();
      chk("single_len", seen.size(), 3);
      if (seen.size() == 3) begin
         chk("single_b0", seen[0], 8'hA5);
         chk("single_b1", seen[1], 8'h12);
         chk("single_b2", seen[2], 8'h34);
         chk("single_span", seen_cyc[2] - seen_cyc[0], 2);
      end

      // Backpressure on byte 12
      sample_valid_i = 1'b1; data_i = 16'h12AB;
      cycle();
      sample_valid_i = 1'b0;
      cycle();
      cycle();
      byte_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("bp_hold_data", data_uart_o, 8'h12);
         chk("bp_hold_valid", byte_valid_o, 1'b1);
      end
      byte_ready_i = 1'b1;
      cycle();
      chk("bp_next", data_uart_o, 8'hAB);
      repeat (3) cycle();

      // Overflow: one sample in the shift register plus DEPTH in the FIFO
      byte_ready_i = 1'b0;
      sample_valid_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         data_i = 16'($urandom);
         cycle();
      end
      chk("ovf_set", overflow_o, 1'b1);
      chk("ovf_full", sample_ready_o, 1'b0);
      clr_ovf_i = 1'b1;
      cycle();
      chk("ovf_set_wins", overflow_o, 1'b1);
      sample_valid_i = 1'b0; clr_ovf_i = 1'b0;
      seen.delete(); seen_cyc.delete();
      byte_ready_i = 1'b1;
      repeat (25) cycle();
      chk("ovf_frames", seen.size(), 5 * FRAME);
      clr_ovf_i = 1'b1;
      cycle();
      clr_ovf_i = 1'b0;
      chk("ovf_clear", overflow_o, 1'b0);

      // Back-to-back frames
      seen.delete(); seen_cyc.delete();
      sample_valid_i = 1'b1; data_i = 16'hAAAA;
      cycle();
      data_i = 16'h5555;
      cycle();
      sample_valid_i = 1'b0;
      repeat (8) cycle();
      chk("b2b_len", seen.size(), 6);
      if (seen.size() == 6) begin
         chk("b2b_b0", seen[0], 8'hA5);
         chk("b2b_b1", seen[1], 8'hAA);
         chk("b2b_b2", seen[2], 8'hAA);
         chk("b2b_b3", seen[3], 8'hA5);
         chk("b2b_b4", seen[4], 8'h55);
         chk("b2b_b5", seen[5], 8'h55);
         chk("b2b_span", seen_cyc[5] - seen_cyc[0], 5);
      end

      // Reset after the header byte is accepted
      sample_valid_i = 1'b1; data_i = 16'hBEEF;
      cycle();
      sample_valid_i = 1'b0;
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("rst_mid_valid", byte_valid_o, 1'b0);
      chk("rst_mid_ready", sample_ready_o, 1'b1);
      seen.delete(); seen_cyc.delete();
      sample_valid_i = 1'b1; data_i = 16'h0F80;
      cycle();
      sample_valid_i = 1'b0;
      repeat (5) cycle();
      chk("rst_after_len", seen.size(), 3);
      if (seen.size() == 3) begin
         chk("rst_after_b0", seen[0], 8'hA5);
         chk("rst_after_b1", seen[1], 8'h0F);
         chk("rst_after_b2", seen[2], 8'h80);
      end

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         sample_valid_i = ($urandom_range(0, 99) < 45);
         data_i         = 16'($urandom);
         byte_ready_i   = ($urandom_range(0, 99) < 70);
         clr_ovf_i      = ($urandom_range(0, 99) < 8);
         rst            = ($urandom_range(0, 199) == 0);
         cycle();
      end
      rst = 1'b0; sample_valid_i = 1'b0; byte_ready_i = 1'b1; clr_ovf_i = 1'b0;
      repeat (25) cycle();
      chk("drain_empty", exp_q.size(), 0);
      chk("drain_idle", byte_valid_o, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
